// File: rtl/memory_arbiter.sv
// Shared-RAM arbiter: data requests normally beat instruction fetches, with a
// starvation override, round-robin fairness per class and a per-grant timeout.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS       = 2,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  ramstate_t             ramstate,
  output logic                  fault
);
  localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] owner_reg, owner_next;
  logic [OW-1:0] rr_reg, rr_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          fault_reg, fault_next;
  logic          ipend_reg, ipend_next;

  logic [OW:0]   dsel, isel;
  logic [OW-1:0] rr_after_owner;
  logic          owner_req;

  // Returns {found, index} of the first set bit at or after base, wrapping.
  function automatic logic [OW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [OW-1:0]   base);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      idx = int'(base) + i;
      if (idx >= CPUS) idx = idx - CPUS;
      if (req[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  assign dsel = rr_pick(dREN | dWEN, rr_reg);
  assign isel = rr_pick(iREN, rr_reg);
  assign rr_after_owner = (owner_reg == OW'(CPUS - 1)) ? '0 : owner_reg + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_reg     <= '0;
      starve_reg <= '0;
      tmo_reg    <= '0;
      fault_reg  <= 1'b0;
      ipend_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_reg     <= rr_next;
      starve_reg <= starve_next;
      tmo_reg    <= tmo_next;
      fault_reg  <= fault_next;
      ipend_reg  <= ipend_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_next     = rr_reg;
    starve_next = starve_reg;
    tmo_next    = tmo_reg;
    fault_next  = fault_reg;
    ipend_next  = ipend_reg;
    owner_req   = 1'b0;
    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (isel[OW] && (starve_reg >= SW'(STARVE_LIM))) begin
          state_next = ISERV;
          owner_next = isel[OW-1:0];
        end else if (dsel[OW]) begin
          state_next = DSERV;
          owner_next = dsel[OW-1:0];
          ipend_next = |iREN;
        end else if (isel[OW]) begin
          state_next = ISERV;
          owner_next = isel[OW-1:0];
        end
      end
      DSERV, ISERV: begin
        owner_req = (state_reg == DSERV) ? (dREN[owner_reg] | dWEN[owner_reg])
                                         : iREN[owner_reg];
        if (ramstate == ACCESS) begin
          state_next = IDLE;
          rr_next    = rr_after_owner;
          tmo_next   = '0;
          // Starvation is only charged for completed data grants that overtook a fetch.
          if (state_reg == ISERV)
            starve_next = '0;
          else if (ipend_reg && (starve_reg < SW'(STARVE_LIM)))
            starve_next = starve_reg + 1'b1;
        end else if (!owner_req) begin
          state_next = IDLE;
          tmo_next   = '0;
        end else if (tmo_reg >= TW'(TIMEOUT - 1)) begin
          state_next = IDLE;
          fault_next = 1'b1;
          tmo_next   = '0;
          rr_next    = rr_after_owner;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    case (state_reg)
      DSERV: begin
        ramREN   = dREN[owner_reg];
        ramWEN   = dWEN[owner_reg] & ~dREN[owner_reg];
        ramaddr  = daddr[owner_reg];
        ramstore = dstore[owner_reg];
        if (ramstate == ACCESS) dwait[owner_reg] = 1'b0;
      end
      ISERV: begin
        ramREN  = iREN[owner_reg];
        ramaddr = iaddr[owner_reg];
        if (ramstate == ACCESS) iwait[owner_reg] = 1'b0;
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_load
      assign iload[gi] = ramload;
      assign dload[gi] = ramload;
    end
  endgenerate

  assign fault = fault_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: expected transactions are queued as
// stimulus is applied and matched when a wait bit is released.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [CPUS-1:0]       iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic                  ramREN, ramWEN, fault;
  logic [31:0]           ramaddr, ramstore, ramload;
  ramstate_t             ramstate;

  typedef struct packed {
    logic        is_i;
    logic [7:0]  core;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  memory_arbiter #(.CPUS(CPUS), .STARVE_LIM(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramstate(ramstate), .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    ramload = $urandom;
  endtask

  task automatic push(input logic is_i, input int core, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] store);
    txn_t t;
    t.is_i = is_i; t.core = 8'(core); t.ren = ren; t.wen = wen; t.addr = addr; t.store = store;
    exp_q.push_back(t);
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    ramstate = ACCESS;
    cyc();
    cyc();
    nRST = 1'b1;
  endtask

  task automatic drain(input string tag);
    chk(tag, 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Scoreboard side: any released wait bit is one completed transaction.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && (iwait !== '1 || dwait !== '1)) begin
      txn_t       e;
      logic [7:0] c;
      logic       is_i;
      is_i = (iwait !== '1);
      c = '0;
      for (int i = CPUS - 1; i >= 0; i--)
        if ((is_i ? iwait[i] : dwait[i]) == 1'b0) c = 8'(i);
      $display("txn %s core%0d ren=%0b wen=%0b addr=%h store=%h",
               is_i ? "I" : "D", c, ramREN, ramWEN, ramaddr, ramstore);
      chk("one_wait_low", 64'($countones(~{iwait, dwait})), 1);
      chk("txn_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("kind", 64'(is_i), 64'(e.is_i));
        chk("owner", 64'(c), 64'(e.core));
        chk("ramREN", 64'(ramREN), 64'(e.ren));
        chk("ramWEN", 64'(ramWEN), 64'(e.wen));
        chk("ramaddr", 64'(ramaddr), 64'(e.addr));
        chk("ramstore", 64'(ramstore), 64'(e.store));
        chk("load_lane", 64'(is_i ? iload[c[0]] : dload[c[0]]), 64'(ramload));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with a request pending that must be ignored.
    nRST = 1'b0;
    clear_inputs();
    ramstate = ACCESS;
    ramload = 32'h1234_5678;
    dREN = 2'b01;
    repeat (3) @(negedge CLK);
    chk("rst_ramREN", 64'(ramREN), 0);
    chk("rst_ramWEN", 64'(ramWEN), 0);
    chk("rst_ramaddr", 64'(ramaddr), 0);
    chk("rst_ramstore", 64'(ramstore), 0);
    chk("rst_iwait", 64'(iwait), 64'h3);
    chk("rst_dwait", 64'(dwait), 64'h3);
    chk("rst_fault", 64'(fault), 0);
    chk("iload_lane1", 64'(iload[1]), 64'h1234_5678);
    chk("dload_lane0", 64'(dload[0]), 64'h1234_5678);
    do_reset();

    // Single data read with one-cycle arbitration latency.
    daddr[0] = 32'h40;
    push(1'b0, 0, 1'b1, 1'b0, 32'h40, 32'h0);
    dREN = 2'b01;
    @(negedge CLK);
    chk("s1_arb_latency", 64'(ramREN), 0);
    cyc();
    @(negedge CLK);
    chk("s1_dwait0", 64'(dwait[0]), 0);
    cyc();
    dREN = '0;
    @(negedge CLK);
    chk("s1_idle_ramREN", 64'(ramREN), 0);
    chk("s1_idle_dwait", 64'(dwait), 64'h3);
    drain("s1_drain");

    // Two writers held continuously alternate; ramstore follows the owner.
    do_reset();
    daddr[0] = 32'h100; daddr[1] = 32'h104;
    dstore[0] = 32'hA0A0; dstore[1] = 32'hB1B1;
    push(1'b0, 0, 1'b0, 1'b1, 32'h100, 32'hA0A0);
    push(1'b0, 1, 1'b0, 1'b1, 32'h104, 32'hB1B1);
    push(1'b0, 0, 1'b0, 1'b1, 32'h100, 32'hC0C0);
    push(1'b0, 1, 1'b0, 1'b1, 32'h104, 32'hB1B1);
    dWEN = 2'b11;
    repeat (4) cyc();
    dstore[0] = 32'hC0C0;
    repeat (4) cyc();
    dWEN = '0;
    cyc();
    drain("s2_drain");

    // Instruction starvation: fetch wins the 5th arbitration, then data again.
    do_reset();
    iaddr[1] = 32'h300; daddr[0] = 32'h200; dstore[0] = 32'h11;
    repeat (4) push(1'b0, 0, 1'b1, 1'b0, 32'h200, 32'h11);
    push(1'b1, 1, 1'b1, 1'b0, 32'h300, 32'h0);
    push(1'b0, 0, 1'b1, 1'b0, 32'h200, 32'h11);
    iREN = 2'b10; dREN = 2'b01;
    repeat (12) cyc();
    iREN = '0; dREN = '0;
    cyc();
    drain("s3_drain");

    // Read and write together: read wins.
    do_reset();
    daddr[0] = 32'h44; dstore[0] = 32'h55;
    push(1'b0, 0, 1'b1, 1'b0, 32'h44, 32'h55);
    dREN = 2'b01; dWEN = 2'b01;
    repeat (2) cyc();
    dREN = '0; dWEN = '0;
    cyc();
    drain("s4_drain");

    // Timeout: 255 BUSY serve cycles set a sticky fault with no wait released.
    do_reset();
    ramstate = BUSY;
    daddr[0] = 32'h80;
    dREN = 2'b01;
    cyc();
    repeat (254) cyc();
    @(negedge CLK);
    chk("tmo_fault_before", 64'(fault), 0);
    chk("tmo_still_serving", 64'(ramREN), 1);
    cyc();
    @(negedge CLK);
    chk("tmo_fault_set", 64'(fault), 1);
    chk("tmo_idle", 64'(ramREN), 0);
    chk("tmo_dwait", 64'(dwait), 64'h3);
    dREN = '0;
    repeat (3) cyc();
    chk("fault_sticky", 64'(fault), 1);
    ramstate = ACCESS;
    push(1'b0, 0, 1'b1, 1'b0, 32'h80, 32'h0);
    dREN = 2'b01;
    repeat (2) cyc();
    dREN = '0;
    cyc();
    chk("fault_sticky_after_txn", 64'(fault), 1);
    drain("s5_drain");
    do_reset();
    @(negedge CLK);
    chk("fault_cleared", 64'(fault), 0);

    // Asynchronous reset mid-transaction, then fresh arbitration from core 0.
    ramstate = BUSY;
    daddr[1] = 32'h90;
    dREN = 2'b10;
    cyc();
    @(negedge CLK);
    chk("pre_rst_ramREN", 64'(ramREN), 1);
    chk("pre_rst_ramaddr", 64'(ramaddr), 64'h90);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst_ramREN", 64'(ramREN), 0);
    chk("async_rst_ramaddr", 64'(ramaddr), 0);
    chk("async_rst_dwait", 64'(dwait), 64'h3);
    ramstate = ACCESS;
    daddr[0] = 32'h94;
    dREN = 2'b11;
    cyc();
    nRST = 1'b1;
    push(1'b0, 0, 1'b1, 1'b0, 32'h94, 32'h0);
    repeat (2) cyc();
    dREN = '0;
    cyc();
    drain("s6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
